alu_sched: RTL and testbench

- Two-requester round-robin scheduler that shares one combinational Alu instance.
- Sequences multi-word operations of up to NWORDS x 32 bits, one 32-bit word per cycle, least significant word first.
- Chains the carry between words through the Alu FirstCyc and CI inputs.
- Returns the full result and aggregated flags to the requester that owns the operation.

---
 rtl/alu_sched.sv | 189 ++++++++++++++++++
 tb/tb_alu_sched.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sched.sv
// Two-requester round-robin scheduler sequencing multi-word ops through one shared Alu.
// Optional busy-cycle counter on stat_busy enabled by defining ALU_SCHED_STATS_EN.
module alu_sched #(
    parameter int NWORDS = 2,
    parameter int LENW   = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   r0_req_valid,
    output logic                   r0_req_ready,
    input  logic [3:0]             r0_req_op,
    input  logic [LENW-1:0]        r0_req_len,
    input  logic [32*NWORDS-1:0]   r0_req_a,
    input  logic [32*NWORDS-1:0]   r0_req_b,
    output logic                   r0_rsp_valid,
    input  logic                   r0_rsp_ready,
    input  logic                   r1_req_valid,
    output logic                   r1_req_ready,
    input  logic [3:0]             r1_req_op,
    input  logic [LENW-1:0]        r1_req_len,
    input  logic [32*NWORDS-1:0]   r1_req_a,
    input  logic [32*NWORDS-1:0]   r1_req_b,
    output logic                   r1_rsp_valid,
    input  logic                   r1_rsp_ready,
    output logic [32*NWORDS-1:0]   rsp_z,
    output logic [3:0]             rsp_flags,
    output logic [31:0]            alu_a,
    output logic [31:0]            alu_b,
    output logic [31:0]            alu_di,
    output logic [3:0]             alu_inst,
    output logic                   alu_ci,
    output logic                   alu_first,
    input  logic [31:0]            alu_z,
    input  logic [3:0]             alu_flags,
    output logic [31:0]            stat_busy
);

    // state | meaning
    // IDLE  | waiting for a request; arbitration and grant happen here
    // RUN   | one operand word per cycle through the Alu, word k = 0..len-1
    // DONE  | result held for the owner until its rsp_ready
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int W = 32 * NWORDS;

    state_t              state, state_nxt;
    logic                last_grant;
    logic                owner;
    logic [3:0]          op_q;
    logic [LENW-1:0]     len_q;
    logic [LENW-1:0]     k;
    logic [W-1:0]        a_q, b_q, z_q;
    logic                carry_q, zero_acc, ovf_q;
    logic                gnt0, gnt1, grant;
    logic [LENW-1:0]     len_sel, len_norm;
    logic [31:0]         a_word, b_word;
    logic                last_word;
    logic                unused_flag;

    assign unused_flag = alu_flags[3];

    // last_grant == 1 means r1 was served last, so r0 wins a tie
    assign gnt0  = r0_req_valid & (~r1_req_valid | last_grant);
    assign gnt1  = r1_req_valid & (~r0_req_valid | ~last_grant);
    assign grant = (state == IDLE) & (gnt0 | gnt1);

    assign len_sel   = gnt1 ? r1_req_len : r0_req_len;
    assign last_word = (k == len_q - LENW'(1));

    always_comb begin
        len_norm = len_sel;
        if (len_sel == '0)
            len_norm = LENW'(1);
        else if (len_sel > LENW'(NWORDS))
            len_norm = LENW'(NWORDS);
    end

    always_comb begin
        a_word = '0;
        b_word = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (k == LENW'(i)) begin
                a_word = a_q[i*32 +: 32];
                b_word = b_q[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        r0_req_ready = 1'b0;
        r1_req_ready = 1'b0;
        r0_rsp_valid = 1'b0;
        r1_rsp_valid = 1'b0;
        rsp_flags    = 4'h0;
        alu_a        = '0;
        alu_b        = '0;
        alu_inst     = 4'h0;
        alu_ci       = 1'b0;
        alu_first    = 1'b0;
        case (state)
            IDLE: begin
                r0_req_ready = gnt0;
                r1_req_ready = gnt1;
                if (gnt0 | gnt1)
                    state_nxt = RUN;
            end
            RUN: begin
                alu_a     = a_word;
                alu_b     = b_word;
                alu_inst  = op_q;
                alu_first = (k == '0);
                alu_ci    = (k == '0) ? 1'b0 : carry_q;
                if (last_word)
                    state_nxt = DONE;
            end
            DONE: begin
                rsp_flags    = {1'b0, zero_acc, carry_q, ovf_q};
                r0_rsp_valid = ~owner;
                r1_rsp_valid = owner;
                if (owner ? r1_rsp_ready : r0_rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_q       <= 4'h0;
            len_q      <= '0;
            k          <= '0;
            a_q        <= '0;
            b_q        <= '0;
            z_q        <= '0;
            carry_q    <= 1'b0;
            zero_acc   <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (grant) begin
            last_grant <= gnt1;
            owner      <= gnt1;
            op_q       <= gnt1 ? r1_req_op : r0_req_op;
            len_q      <= len_norm;
            a_q        <= gnt1 ? r1_req_a : r0_req_a;
            b_q        <= gnt1 ? r1_req_b : r0_req_b;
            z_q        <= '0;
            zero_acc   <= 1'b1;
            k          <= '0;
        end else if (state == RUN) begin
            for (int i = 0; i < NWORDS; i++) begin
                if (k == LENW'(i))
                    z_q[i*32 +: 32] <= alu_z;
            end
            carry_q  <= alu_flags[1];
            zero_acc <= zero_acc & alu_flags[2];
            ovf_q    <= alu_flags[0];
            if (!last_word)
                k <= k + LENW'(1);
        end
    end

    assign rsp_z  = z_q;
    assign alu_di = '0;

`ifdef ALU_SCHED_STATS_EN
    logic [31:0] busy_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy_cnt <= '0;
        else if (state == RUN && busy_cnt != 32'hFFFF_FFFF)
            busy_cnt <= busy_cnt + 32'd1;
    end

    assign stat_busy = busy_cnt;
`else
    assign stat_busy = '0;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a small behavioural Alu (op 0 = ADD, op 8 = AND).
// Stats checks follow ALU_SCHED_STATS_EN when the bench is built with it.
module tb_alu_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_req_valid, r0_req_ready, r0_rsp_valid, r0_rsp_ready;
    logic        r1_req_valid, r1_req_ready, r1_rsp_valid, r1_rsp_ready;
    logic [3:0]  r0_req_op, r1_req_op;
    logic [2:0]  r0_req_len, r1_req_len;
    logic [63:0] r0_req_a, r0_req_b, r1_req_a, r1_req_b;
    logic [63:0] rsp_z;
    logic [3:0]  rsp_flags;
    logic [31:0] alu_a, alu_b, alu_di, alu_z;
    logic [3:0]  alu_inst, alu_flags;
    logic        alu_ci, alu_first;
    logic [31:0] stat_busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_sched #(.NWORDS(2), .LENW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_req_op(r0_req_op),
        .r0_req_len(r0_req_len), .r0_req_a(r0_req_a), .r0_req_b(r0_req_b),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
        .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_req_op(r1_req_op),
        .r1_req_len(r1_req_len), .r1_req_a(r1_req_a), .r1_req_b(r1_req_b),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
        .rsp_z(rsp_z), .rsp_flags(rsp_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_di(alu_di), .alu_inst(alu_inst),
        .alu_ci(alu_ci), .alu_first(alu_first), .alu_z(alu_z), .alu_flags(alu_flags),
        .stat_busy(stat_busy)
    );

    // behavioural Alu: flags = {0, zero, carry, ovf}
    always_comb begin
        logic [32:0] s;
        s         = '0;
        alu_z     = '0;
        alu_flags = '0;
        case (alu_inst)
            4'h0: begin
                s     = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_ci};
                alu_z = s[31:0];
                alu_flags[1] = s[32];
                alu_flags[0] = (alu_a[31] == alu_b[31]) && (alu_z[31] != alu_a[31]);
            end
            4'h8: alu_z = alu_a & alu_b;
            default: alu_z = '0;
        endcase
        alu_flags[2] = (alu_z == 32'd0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        r0_req_valid = 0; r1_req_valid = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_op(input bit who, input logic [3:0] op, input logic [2:0] len,
                          input logic [63:0] a, input logic [63:0] b,
                          output int runc, output logic [7:0] first_bits,
                          output logic [7:0] ci_bits, output logic [63:0] z,
                          output logic [3:0] flg, output bit ok);
        int guard;
        ok = 0; runc = 0; first_bits = '0; ci_bits = '0; z = '0; flg = '0;
        @(negedge clk);
        r0_rsp_ready = 1; r1_rsp_ready = 1;
        if (!who) begin
            r0_req_valid = 1; r0_req_op = op; r0_req_len = len; r0_req_a = a; r0_req_b = b;
        end else begin
            r1_req_valid = 1; r1_req_op = op; r1_req_len = len; r1_req_a = a; r1_req_b = b;
        end
        #1;
        guard = 0;
        while (!(who ? r1_req_ready : r0_req_ready) && guard < 20) begin
            @(negedge clk); #1; guard++;
        end
        if (guard >= 20) begin
            r0_req_valid = 0; r1_req_valid = 0;
            return;
        end
        @(negedge clk);
        r0_req_valid = 0; r1_req_valid = 0;
        #1;
        guard = 0;
        while (!(who ? r1_rsp_valid : r0_rsp_valid) && guard < 20) begin
            if (runc < 8) begin
                first_bits[runc] = alu_first;
                ci_bits[runc]    = alu_ci;
            end
            runc++;
            @(negedge clk); #1; guard++;
        end
        if (guard >= 20) return;
        z = rsp_z; flg = rsp_flags; ok = 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [255:0] outs;
        rst_n = 0;
        r0_req_valid = 0; r1_req_valid = 0; r0_rsp_ready = 0; r1_rsp_ready = 0;
        r0_req_op = 0; r1_req_op = 0; r0_req_len = 0; r1_req_len = 0;
        r0_req_a = 0; r0_req_b = 0; r1_req_a = 0; r1_req_b = 0;
        #12;
        outs = {r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid, rsp_z, rsp_flags,
                alu_a, alu_b, alu_di, alu_inst, alu_ci, alu_first, stat_busy};
        n_checks++;
        if (outs !== '0) $display("FAIL reset_outputs: got %h want 0", outs);
        else n_pass++;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_and_op();
        int rc; logic [7:0] fb, cb; logic [63:0] z; logic [3:0] f; bit ok;
        run_op(0, 4'h8, 3'd2, 64'hFFFF0000_12345678, 64'h0F0F0F0F_FFFF0000, rc, fb, cb, z, f, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL and_timeout: ok=%0d want 1", ok); else n_pass++;
        n_checks++;
        if (rc !== 2) $display("FAIL and_run_cycles: got %0d want 2", rc); else n_pass++;
        n_checks++;
        if (fb[1:0] !== 2'b01) $display("FAIL and_first_seq: got %b want 01", fb[1:0]); else n_pass++;
        n_checks++;
        if (z !== 64'h0F0F0000_12340000) $display("FAIL and_z: got %h want 0f0f000012340000", z); else n_pass++;
        n_checks++;
        if (f !== 4'h0) $display("FAIL and_flags: got %h want 0", f); else n_pass++;
    endtask

    task automatic test_carry_chain();
        int rc; logic [7:0] fb, cb; logic [63:0] z; logic [3:0] f; bit ok;
        run_op(0, 4'h0, 3'd2, 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_00000001, rc, fb, cb, z, f, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL carry_timeout: ok=%0d want 1", ok); else n_pass++;
        n_checks++;
        if (cb[1:0] !== 2'b10) $display("FAIL carry_ci_seq: got %b want 10", cb[1:0]); else n_pass++;
        n_checks++;
        if (z !== 64'h0) $display("FAIL carry_z: got %h want 0", z); else n_pass++;
        n_checks++;
        if (f !== 4'h6) $display("FAIL carry_flags: got %h want 6", f); else n_pass++;
    endtask

    task automatic test_len_clamp();
        int rc; logic [7:0] fb, cb; logic [63:0] z; logic [3:0] f; bit ok;
        run_op(1, 4'h0, 3'd0, 64'hAAAAAAAA_7FFFFFFF, 64'h55555555_00000001, rc, fb, cb, z, f, ok);
        n_checks++;
        if (rc !== 1 || ok !== 1'b1) $display("FAIL len0_run_cycles: got %0d ok=%0d want 1", rc, ok); else n_pass++;
        n_checks++;
        if (z !== 64'h00000000_80000000) $display("FAIL len0_z: got %h want 0000000080000000", z); else n_pass++;
        n_checks++;
        if (f !== 4'h1) $display("FAIL len0_flags: got %h want 1", f); else n_pass++;
        run_op(0, 4'h8, 3'd7, 64'hF0F0F0F0_0000FFFF, 64'hFFFFFFFF_FFFF0000, rc, fb, cb, z, f, ok);
        n_checks++;
        if (rc !== 2 || ok !== 1'b1) $display("FAIL len7_run_cycles: got %0d ok=%0d want 2", rc, ok); else n_pass++;
        n_checks++;
        if (z !== 64'hF0F0F0F0_00000000) $display("FAIL len7_z: got %h want f0f0f0f000000000", z); else n_pass++;
    endtask

    task automatic test_contention();
        int ng, cyc, both;
        logic [3:0] ord;
        apply_reset();
        @(negedge clk);
        r0_rsp_ready = 1; r1_rsp_ready = 1;
        r0_req_op = 4'h8; r0_req_len = 3'd1; r0_req_a = 64'h1; r0_req_b = 64'h1;
        r1_req_op = 4'h8; r1_req_len = 3'd1; r1_req_a = 64'h2; r1_req_b = 64'h2;
        r0_req_valid = 1; r1_req_valid = 1;
        #1;
        ng = 0; cyc = 0; both = 0; ord = '0;
        while (ng < 4 && cyc < 100) begin
            if (r0_req_ready && r1_req_ready) both++;
            if (r0_req_ready) begin ord[ng] = 1'b0; ng++; end
            else if (r1_req_ready) begin ord[ng] = 1'b1; ng++; end
            @(negedge clk); #1; cyc++;
        end
        r0_req_valid = 0; r1_req_valid = 0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (ng !== 4) $display("FAIL contention_grants: got %0d want 4", ng); else n_pass++;
        n_checks++;
        if (ord !== 4'b1010) $display("FAIL contention_order: got %b want 1010 (bit0 first)", ord); else n_pass++;
        n_checks++;
        if (both !== 0) $display("FAIL contention_dual_ready: got %0d want 0", both); else n_pass++;
    endtask

    task automatic test_backpressure();
        int guard;
        logic [70:0] obs;
        @(negedge clk);
        r0_rsp_ready = 1; r1_rsp_ready = 0;
        r1_req_op = 4'h8; r1_req_len = 3'd1;
        r1_req_a = 64'h12345678_0000FFFF; r1_req_b = 64'h00000000_00FF00FF;
        r1_req_valid = 1;
        #1;
        guard = 0;
        while (!r1_req_ready && guard < 20) begin @(negedge clk); #1; guard++; end
        @(negedge clk);
        r1_req_valid = 0;
        r0_req_op = 4'h8; r0_req_len = 3'd1; r0_req_a = 64'h1; r0_req_b = 64'h3;
        r0_req_valid = 1;
        #1;
        guard = 0;
        while (!r1_rsp_valid && guard < 20) begin @(negedge clk); #1; guard++; end
        n_checks++;
        if (guard >= 20) $display("FAIL bp_rsp_timeout: r1_rsp_valid=%b want 1", r1_rsp_valid); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            obs = {r1_rsp_valid, r0_rsp_valid, r0_req_ready, rsp_flags, rsp_z};
            n_checks++;
            if (obs !== {3'b100, 4'h0, 64'h00000000_000000FF})
                $display("FAIL bp_hold_%0d: got %h want %h", i, obs, {3'b100, 4'h0, 64'h00000000_000000FF});
            else n_pass++;
            @(negedge clk); #1;
        end
        r1_rsp_ready = 1;
        #1;
        n_checks++;
        if (r0_req_ready !== 1'b0) $display("FAIL bp_early_grant: got %b want 0", r0_req_ready); else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (r0_req_ready !== 1'b1) $display("FAIL bp_r0_grant: got %b want 1", r0_req_ready); else n_pass++;
        @(negedge clk);
        r0_req_valid = 0;
        #1;
        guard = 0;
        while (!r0_rsp_valid && guard < 20) begin @(negedge clk); #1; guard++; end
        n_checks++;
        if (rsp_z !== 64'h1 || r0_rsp_valid !== 1'b1)
            $display("FAIL bp_r0_result: got z=%h valid=%b want z=1 valid=1", rsp_z, r0_rsp_valid);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int guard, seen;
        logic [255:0] outs;
        @(negedge clk);
        r0_rsp_ready = 1; r1_rsp_ready = 1;
        r0_req_op = 4'h0; r0_req_len = 3'd2; r0_req_a = 64'h5; r0_req_b = 64'h6;
        r0_req_valid = 1;
        #1;
        guard = 0;
        while (!r0_req_ready && guard < 20) begin @(negedge clk); #1; guard++; end
        @(negedge clk);
        r0_req_valid = 0;
        #1;
        n_checks++;
        if ({alu_first, alu_a, alu_b} !== {1'b1, 32'h5, 32'h6})
            $display("FAIL midrun_word0: got first=%b a=%h b=%h want 1 5 6", alu_first, alu_a, alu_b);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (alu_first !== 1'b0) $display("FAIL midrun_word1: got first=%b want 0", alu_first); else n_pass++;
        rst_n = 0;
        #1;
        outs = {r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid, rsp_z, rsp_flags,
                alu_a, alu_b, alu_di, alu_inst, alu_ci, alu_first, stat_busy};
        n_checks++;
        if (outs !== '0) $display("FAIL midrun_reset_outputs: got %h want 0", outs); else n_pass++;
        @(negedge clk);
        rst_n = 1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (r0_rsp_valid || r1_rsp_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) $display("FAIL midrun_no_rsp: got %0d valid cycles want 0", seen); else n_pass++;
    endtask

    task automatic test_stats();
        int rc; logic [7:0] fb, cb; logic [63:0] z; logic [3:0] f; bit ok;
        n_checks++;
        if (stat_busy !== 32'd0) $display("FAIL stats_after_reset: got %0d want 0", stat_busy); else n_pass++;
        run_op(0, 4'h8, 3'd2, 64'h3, 64'h1, rc, fb, cb, z, f, ok);
`ifdef ALU_SCHED_STATS_EN
        n_checks++;
        if (stat_busy !== 32'd2) $display("FAIL stats_len2: got %0d want 2", stat_busy); else n_pass++;
        run_op(1, 4'h8, 3'd1, 64'h3, 64'h1, rc, fb, cb, z, f, ok);
        n_checks++;
        if (stat_busy !== 32'd3) $display("FAIL stats_len1: got %0d want 3", stat_busy); else n_pass++;
`else
        n_checks++;
        if (stat_busy !== 32'd0) $display("FAIL stats_disabled: got %0d want 0", stat_busy); else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_and_op();
        test_carry_chain();
        test_len_clamp();
        test_contention();
        test_backpressure();
        test_reset_mid_run();
        test_stats();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
